// File: rtl/morse_receiver.sv
// Morse receiver: synchronizes an on/off key line, times marks and spaces in units and
// decodes each completed character to ASCII, flagging word gaps and bad patterns.
module morse_receiver #(
  parameter int unsigned UNIT_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_key_in,
  output logic       o_char_valid,
  output logic [7:0] o_char_ascii,
  output logic [2:0] o_sym_len,
  output logic [4:0] o_sym_bits,
  output logic       o_word_gap,
  output logic       o_error
);

  localparam int unsigned PW = $clog2(UNIT_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(UNIT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic          r_key_meta;
  logic          r_key_s;
  logic          r_key_prev;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_units;
  logic [1:0]    r_state;
  logic [1:0]    r_prior;
  logic [2:0]    r_len;
  logic [4:0]    r_bits;
  logic          r_ovf;

  logic          w_rise;
  logic          w_fall;
  logic          w_edge;
  logic          w_tick;
  logic          w_emit;
  logic          w_wgap;
  logic          w_dash;
  logic [7:0]    w_lut_ascii;
  logic          w_lut_hit;

  assign w_rise = r_key_s & ~r_key_prev;
  assign w_fall = ~r_key_s & r_key_prev;
  assign w_edge = w_rise | w_fall;
  // An edge suppresses the tick, so an edge coinciding with a threshold ends the space instead.
  assign w_tick = ~w_edge && (r_presc == PRESC_MAX);
  assign w_emit = (r_state == ST_SPACE) && w_tick && (r_units == 4'd2);
  assign w_wgap = (r_state == ST_GAP) && w_tick && (r_units == 4'd6);
  assign w_dash = (r_units >= 4'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
      r_key_prev <= 1'b0;
    end else begin
      r_key_meta <= i_key_in;
      r_key_s    <= r_key_meta;
      r_key_prev <= r_key_s;
    end
  end

  // The edge cycle is phase 0 of the new level, so the prescaler restarts at 1 after it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
      r_units <= 4'd0;
    end else if (w_edge) begin
      r_presc <= PW'(1);
      r_units <= 4'd0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_units != 4'd15) r_units <= r_units + 4'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_prior <= ST_IDLE;
      r_len   <= 3'd0;
      r_bits  <= 5'd0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_rise) begin
            r_prior <= r_state;
            r_state <= ST_MARK;
          end else if (w_wgap) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SPACE: begin
          if (w_rise) begin
            r_prior <= ST_SPACE;
            r_state <= ST_MARK;
          end else if (w_emit) begin
            r_state <= ST_GAP;
            r_len   <= 3'd0;
            r_bits  <= 5'd0;
            r_ovf   <= 1'b0;
          end
        end
        ST_MARK: begin
          if (w_fall) begin
            if (r_units == 4'd0) begin
              r_state <= r_prior;
            end else begin
              r_state <= ST_SPACE;
              if (r_ovf || (r_len >= 3'd5)) begin
                r_ovf <= 1'b1;
                r_len <= 3'd6;
              end else begin
                r_bits <= r_bits | (5'(w_dash) << r_len);
                r_len  <= r_len + 3'd1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ITU table keyed on {length, pattern}; bit0 is the first symbol, 1 = dash.
  always_comb begin
    w_lut_hit   = 1'b1;
    w_lut_ascii = 8'h3F;
    case ({r_len, r_bits})
      {3'd2, 5'b00010}: w_lut_ascii = 8'h41;
      {3'd4, 5'b00001}: w_lut_ascii = 8'h42;
      {3'd4, 5'b00101}: w_lut_ascii = 8'h43;
      {3'd3, 5'b00001}: w_lut_ascii = 8'h44;
      {3'd1, 5'b00000}: w_lut_ascii = 8'h45;
      {3'd4, 5'b00100}: w_lut_ascii = 8'h46;
      {3'd3, 5'b00011}: w_lut_ascii = 8'h47;
      {3'd4, 5'b00000}: w_lut_ascii = 8'h48;
      {3'd2, 5'b00000}: w_lut_ascii = 8'h49;
      {3'd4, 5'b01110}: w_lut_ascii = 8'h4A;
      {3'd3, 5'b00101}: w_lut_ascii = 8'h4B;
      {3'd4, 5'b00010}: w_lut_ascii = 8'h4C;
      {3'd2, 5'b00011}: w_lut_ascii = 8'h4D;
      {3'd2, 5'b00001}: w_lut_ascii = 8'h4E;
      {3'd3, 5'b00111}: w_lut_ascii = 8'h4F;
      {3'd4, 5'b00110}: w_lut_ascii = 8'h50;
      {3'd4, 5'b01011}: w_lut_ascii = 8'h51;
      {3'd3, 5'b00010}: w_lut_ascii = 8'h52;
      {3'd3, 5'b00000}: w_lut_ascii = 8'h53;
      {3'd1, 5'b00001}: w_lut_ascii = 8'h54;
      {3'd3, 5'b00100}: w_lut_ascii = 8'h55;
      {3'd4, 5'b01000}: w_lut_ascii = 8'h56;
      {3'd3, 5'b00110}: w_lut_ascii = 8'h57;
      {3'd4, 5'b01001}: w_lut_ascii = 8'h58;
      {3'd4, 5'b01101}: w_lut_ascii = 8'h59;
      {3'd4, 5'b00011}: w_lut_ascii = 8'h5A;
      {3'd5, 5'b11111}: w_lut_ascii = 8'h30;
      {3'd5, 5'b11110}: w_lut_ascii = 8'h31;
      {3'd5, 5'b11100}: w_lut_ascii = 8'h32;
      {3'd5, 5'b11000}: w_lut_ascii = 8'h33;
      {3'd5, 5'b10000}: w_lut_ascii = 8'h34;
      {3'd5, 5'b00000}: w_lut_ascii = 8'h35;
      {3'd5, 5'b00001}: w_lut_ascii = 8'h36;
      {3'd5, 5'b00011}: w_lut_ascii = 8'h37;
      {3'd5, 5'b00111}: w_lut_ascii = 8'h38;
      {3'd5, 5'b01111}: w_lut_ascii = 8'h39;
      default:          w_lut_hit   = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_char_valid <= 1'b0;
      o_char_ascii <= 8'h00;
      o_sym_len    <= 3'd0;
      o_sym_bits   <= 5'd0;
      o_word_gap   <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_char_valid <= w_emit;
      o_word_gap   <= w_wgap;
      o_error      <= w_emit && (r_ovf || !w_lut_hit);
      if (w_emit) begin
        o_char_ascii <= (r_ovf || !w_lut_hit) ? 8'h3F : w_lut_ascii;
        o_sym_len    <= r_len;
        o_sym_bits   <= r_bits;
      end
    end
  end

endmodule

// File: doc/morse_receiver.md
# morse_receiver

Decodes an on/off-keyed Morse line back into characters. It is the receive-side counterpart of the Morse transmitter path. It synchronizes the raw key line, times marks and spaces in Morse units, and classifies each mark as a dot or a dash. On each character gap it emits the ASCII code for letters A–Z and digits 0–9, and it flags word gaps and decode errors.

## Interface
- UNIT_CYCLES, default 1000: clock cycles per Morse time unit (≥2).
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- KEY_IN  in  1  raw key line (1 = tone/mark), asynchronous to CLK.
- CHAR_VALID  out  1  one-cycle pulse; CHAR_ASCII/SYM_LEN/SYM_BITS valid this cycle.
- CHAR_ASCII  out  8  decoded character; 8'h3F ('?') on error.
- SYM_LEN  out  3  number of symbols in the character (1–5; 6 means overflow).
- SYM_BITS  out  5  symbol pattern; bit0 = first symbol; 1 = dash, 0 = dot.
- WORD_GAP  out  1  one-cycle pulse when a space reaches 7 units after a character.
- ERROR  out  1  one-cycle pulse, coincident with CHAR_VALID, on unknown pattern or >5 symbols.

## Operation
- **Synchronizer:** two flops, KEY_IN → KEY_S. Both reset to 0. Edge detect compares KEY_S with its previous value, which also resets to 0.
- **Unit timer:** the prescaler clears to 0 on every KEY_S edge. When prescaler == UNIT_CYCLES-1, it wraps to 0 and UNITS increments. UNITS is 4 bits, clears on every edge and saturates at 15. A level lasting L cycles yields UNITS = floor(L/UNIT_CYCLES).
- **Mark classification**, evaluated at the falling edge of KEY_S using UNITS of the mark just ended:
  - 0: glitch. No symbol is added and the state returns to what it was before the mark.
  - 1–2: dot. Shift 0 into SYM_BITS at position SYM_LEN, then SYM_LEN+1.
  - ≥3: dash. Shift 1 in the same way.
  - 6th symbol: set the internal overflow flag. SYM_LEN holds at 6 and SYM_BITS is unchanged.
- **FSM states:**
  - IDLE: no symbols pending. Rising edge → MARK.
  - MARK: falling edge → SPACE, after classification. If the mark was a glitch → the prior state (IDLE or GAP).
  - SPACE: symbols pending. Rising edge → MARK. UNITS reaching 3 → emit character → GAP.
  - GAP: character emitted. Rising edge → MARK. UNITS reaching 7 → WORD_GAP pulse → IDLE.
- **Emit:** CHAR_VALID=1 for one cycle, with the captured SYM_LEN and SYM_BITS on the outputs.
  - CHAR_ASCII comes from a lookup of (SYM_LEN, SYM_BITS) over ITU A–Z and 0–9.
  - If there is no match, or the overflow flag is set: CHAR_ASCII=8'h3F and ERROR=1.
  - The symbol accumulator and overflow flag then clear.
- **Output holding:** CHAR_ASCII, SYM_LEN and SYM_BITS hold their last emitted values until the next emit.
- **WORD_GAP:** fires at most once per gap, and only from GAP. A long silence from IDLE produces nothing.

## Timing
- **Reset values:**
  - All outputs 0.
  - FSM IDLE; accumulator, overflow flag, prescaler, UNITS and synchronizer all 0.
- **RESET priority:** RESET has priority over every event. Asserting it mid-character discards pending symbols, and no CHAR_VALID follows.
- **Key held high through reset:** KEY_S rises 2 cycles after RESET deasserts. This is treated as a normal rising edge.
- **Input latency:** KEY_IN to KEY_S is 2 cycles.
- **Character output:** let t0 be the first cycle KEY_S is low after a mark. UNITS reaches 3 at t0+3·UNIT_CYCLES−1, and CHAR_VALID is high at cycle t0+3·UNIT_CYCLES. All outputs are registered.
- **Word gap output:** WORD_GAP is high at t0+7·UNIT_CYCLES, measured from the same falling edge.
- **Simultaneous events:** if a rising edge of KEY_S coincides with a tick that would make UNITS reach 3 (or 7), the edge wins. The space ends, and no emit or WORD_GAP occurs.
- **Pulse spacing:** CHAR_VALID and WORD_GAP are never high in the same cycle. The minimum spacing between them is 4·UNIT_CYCLES.

## Test plan
Benches use UNIT_CYCLES=4.

1. **Reset:** RESET=1 for 3 cycles with KEY_IN=1 → all outputs 0 during reset. After release, KEY_S rises at +2 cycles and no output pulses during reset.
2. **'E':** KEY_IN high 4 cycles, then low 40 → one CHAR_VALID with CHAR_ASCII=8'h45, SYM_LEN=1, SYM_BITS=5'b00000, ERROR=0. Then one WORD_GAP exactly 16 cycles after CHAR_VALID.
3. **'A' then 'N':** mark 4, space 4, mark 12, space 12, then mark 12, space 4, mark 4, space 12 → CHAR_VALID with 8'h41 (len 2, bits 00010), then CHAR_VALID with 8'h4E (len 2, bits 00001). No WORD_GAP between them.
4. **Glitch:** from IDLE, KEY_IN high 3 cycles then low 40 → no CHAR_VALID, no WORD_GAP, no ERROR.
5. **Overflow:** six dots (mark 4 / space 4 each), then space 12 → CHAR_VALID=1 and ERROR=1 in the same cycle, CHAR_ASCII=8'h3F, SYM_LEN=6. The next 'E' then decodes to 8'h45 with ERROR=0.
6. **Reset mid-character:** two dots sent, then RESET for 1 cycle during the following space, then 40 low cycles → no CHAR_VALID, no WORD_GAP; the next 'T' (mark 12, space 12) decodes to 8'h54.
